// File: rtl/mac36_pkg.sv
// ---------------------------------------------------------------------------
// mac36_pkg
// Shared constants, types and helpers for the 36-lane MAC accumulator.
//   N        : product lanes per bus
//   PROD_W   : width of one signed product lane
//   SUM_W    : adder-tree output width (PROD_W + one bit per tree level)
//   TREE_LAT : registered levels in the adder tree
//   ACC_W_DEF / CNT_W_DEF : default accumulator and beat-counter widths
// Lane convention: lane i (1..N) sits at bits [PROD_W*i-1 -: PROD_W],
// i.e. zero-based lane k sits at [k*PROD_W +: PROD_W].
// ---------------------------------------------------------------------------
package mac36_pkg;

  localparam int N         = 36;
  localparam int PROD_W    = 16;
  localparam int SUM_W     = 22;
  localparam int TREE_LAT  = 6;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W_DEF = 16;

  // Sideband travelling through the tree alongside the data.
  typedef struct packed {
    logic valid;
    logic last;
  } side_t;

  // Extract zero-based lane idx from a product bus, sign-extended by one bit
  // so that a pair of lanes can be added without overflow.
  function automatic logic [PROD_W:0] lane_sx(input logic [N*PROD_W-1:0] bus,
                                               input int idx);
    logic [PROD_W-1:0] v;
    v = bus[idx*PROD_W +: PROD_W];
    return {v[PROD_W-1], v};
  endfunction

endpackage

// File: rtl/mac_acc_36_if.sv
// ---------------------------------------------------------------------------
// mac_acc_36_if
// Bundles the product-input beat and the burst-result output of mac_acc_36.
//   in_valid / in_last : beat qualifier and end-of-burst marker
//   prod1 / prod2      : N x PROD_W signed product buses
//   acc1 / acc2        : burst sums, valid while out_valid = 1
//   beat_cnt           : valid beats in the reported burst
//   out_valid          : one-cycle pulse per completed burst
// master = product source (drives beats), slave = mac_acc_36.
// ---------------------------------------------------------------------------
interface mac_acc_36_if
  import mac36_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic                  in_valid;
  logic                  in_last;
  logic [N*PROD_W-1:0]   prod1;
  logic [N*PROD_W-1:0]   prod2;
  logic [ACC_W-1:0]      acc1;
  logic [ACC_W-1:0]      acc2;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  out_valid;

  modport master (
    output in_valid, in_last, prod1, prod2,
    input  acc1, acc2, beat_cnt, out_valid
  );

  modport slave (
    input  in_valid, in_last, prod1, prod2,
    output acc1, acc2, beat_cnt, out_valid
  );

endinterface

// File: rtl/adder_tree_36.sv
// ---------------------------------------------------------------------------
// adder_tree_36
// Six-level pipelined signed reduction of N=36 PROD_W-bit lanes into one
// SUM_W-bit sum: 36 -> 18 -> 9 -> 5 -> 3 -> 2 -> 1. Each level widens by one
// bit; an odd leftover element is sign-extended and registered through.
// A valid/last sideband shifts in lockstep with the data.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (sideband only)
//   i_data    : N x PROD_W signed lanes
//   i_valid   : beat valid
//   i_last    : last beat of burst (masked by i_valid)
//   o_sum     : SUM_W-bit sum, TREE_LAT cycles after i_data
//   o_valid   : delayed i_valid
//   o_last    : delayed i_valid & i_last
// ---------------------------------------------------------------------------
module adder_tree_36
  import mac36_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*PROD_W-1:0]  i_data,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic [SUM_W-1:0]     o_sum,
  output logic                 o_valid,
  output logic                 o_last
);

  logic [PROD_W:0]   r_l1 [18];
  logic [PROD_W+1:0] r_l2 [9];
  logic [PROD_W+2:0] r_l3 [5];
  logic [PROD_W+3:0] r_l4 [3];
  logic [PROD_W+4:0] r_l5 [2];
  logic [PROD_W+5:0] r_l6;

  side_t r_side [TREE_LAT];

  // Tree data levels; data registers carry no reset, the sideband decides
  // whether their contents are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 18; i++) begin
      r_l1[i] <= lane_sx(i_data, 2*i) + lane_sx(i_data, 2*i + 1);
    end
    for (int i = 0; i < 9; i++) begin
      r_l2[i] <= {r_l1[2*i][PROD_W], r_l1[2*i]}
               + {r_l1[2*i+1][PROD_W], r_l1[2*i+1]};
    end
    for (int i = 0; i < 4; i++) begin
      r_l3[i] <= {r_l2[2*i][PROD_W+1], r_l2[2*i]}
               + {r_l2[2*i+1][PROD_W+1], r_l2[2*i+1]};
    end
    r_l3[4] <= {r_l2[8][PROD_W+1], r_l2[8]};
    for (int i = 0; i < 2; i++) begin
      r_l4[i] <= {r_l3[2*i][PROD_W+2], r_l3[2*i]}
               + {r_l3[2*i+1][PROD_W+2], r_l3[2*i+1]};
    end
    r_l4[2] <= {r_l3[4][PROD_W+2], r_l3[4]};
    r_l5[0] <= {r_l4[0][PROD_W+3], r_l4[0]} + {r_l4[1][PROD_W+3], r_l4[1]};
    r_l5[1] <= {r_l4[2][PROD_W+3], r_l4[2]};
    r_l6    <= {r_l5[0][PROD_W+4], r_l5[0]} + {r_l5[1][PROD_W+4], r_l5[1]};
  end

  // Sideband shift register; last is only meaningful together with valid,
  // so it is masked on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TREE_LAT; i++) begin
        r_side[i] <= '{valid: 1'b0, last: 1'b0};
      end
    end else begin
      r_side[0] <= '{valid: i_valid, last: i_valid & i_last};
      for (int i = 1; i < TREE_LAT; i++) begin
        r_side[i] <= r_side[i-1];
      end
    end
  end

  assign o_sum   = r_l6;
  assign o_valid = r_side[TREE_LAT-1].valid;
  assign o_last  = r_side[TREE_LAT-1].last;

endmodule

// File: rtl/mac_acc_36.sv
// ---------------------------------------------------------------------------
// mac_acc_36
// Reduces both 36-lane product buses with pipelined adder trees and
// accumulates the per-beat sums over a burst ending with in_last. At the
// end of each burst the two sums and the beat count are published with a
// one-cycle out_valid pulse. No backpressure.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   io   : mac_acc_36_if.slave
//            in_valid, in_last, prod1, prod2  (inputs)
//            acc1, acc2, beat_cnt, out_valid  (registered outputs)
// A beat launched at edge t (sampled at t+1) is reported at edge t+7:
// six tree levels plus the accumulate register.
// ---------------------------------------------------------------------------
module mac_acc_36
  import mac36_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
)
(
  input  logic           clk,
  input  logic           rst,
  mac_acc_36_if.slave    io
);

  logic [SUM_W-1:0] w_sum1;
  logic [SUM_W-1:0] w_sum2;
  logic             w_tv1;
  logic             w_tl1;
  logic             w_tv2;
  logic             w_tl2;
  logic             w_tv;
  logic             w_tl;
  logic [ACC_W-1:0] w_sum1_ext;
  logic [ACC_W-1:0] w_sum2_ext;

  logic [ACC_W-1:0] w_acc1_nxt;
  logic [ACC_W-1:0] w_acc2_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [ACC_W-1:0] r_acc1;
  logic [ACC_W-1:0] r_acc2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  logic [ACC_W-1:0] r_acc1_out;
  logic [ACC_W-1:0] r_acc2_out;
  logic [CNT_W-1:0] r_cnt_out;
  logic             r_out_valid;

  adder_tree_36 u_tree1 (
    .clk     (clk),
    .rst     (rst),
    .i_data  (io.prod1),
    .i_valid (io.in_valid),
    .i_last  (io.in_last),
    .o_sum   (w_sum1),
    .o_valid (w_tv1),
    .o_last  (w_tl1)
  );

  adder_tree_36 u_tree2 (
    .clk     (clk),
    .rst     (rst),
    .i_data  (io.prod2),
    .i_valid (io.in_valid),
    .i_last  (io.in_last),
    .o_sum   (w_sum2),
    .o_valid (w_tv2),
    .o_last  (w_tl2)
  );

  // Both trees carry identical sideband; requiring agreement means a
  // corrupted sideband bit in either tree suppresses the beat rather than
  // pairing it with stale data from the other bus.
  assign w_tv = w_tv1 & w_tv2;
  assign w_tl = w_tl1 & w_tl2;

  assign w_sum1_ext = {{(ACC_W-SUM_W){w_sum1[SUM_W-1]}}, w_sum1};
  assign w_sum2_ext = {{(ACC_W-SUM_W){w_sum2[SUM_W-1]}}, w_sum2};

  // Next accumulator/count: load on the first beat of a burst, add
  // (wrapping) afterwards; the count saturates at all-ones.
  always_comb begin
    w_acc1_nxt = r_acc1;
    w_acc2_nxt = r_acc2;
    w_cnt_nxt  = r_cnt;
    if (w_tv) begin
      if (r_first) begin
        w_acc1_nxt = w_sum1_ext;
        w_acc2_nxt = w_sum2_ext;
        w_cnt_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        w_acc1_nxt = r_acc1 + w_sum1_ext;
        w_acc2_nxt = r_acc2 + w_sum2_ext;
        if (&r_cnt) begin
          w_cnt_nxt = r_cnt;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      w_acc1_nxt = r_acc1;
      w_acc2_nxt = r_acc2;
      w_cnt_nxt  = r_cnt;
    end
  end

  // Accumulator state and burst-boundary tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc1  <= {ACC_W{1'b0}};
      r_acc2  <= {ACC_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_first <= 1'b1;
    end else begin
      r_acc1 <= w_acc1_nxt;
      r_acc2 <= w_acc2_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_tv) begin
        r_first <= w_tl;
      end else begin
        r_first <= r_first;
      end
    end
  end

  // Published result: captured with the final beat's update, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc1_out  <= {ACC_W{1'b0}};
      r_acc2_out  <= {ACC_W{1'b0}};
      r_cnt_out   <= {CNT_W{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_tv & w_tl;
      if (w_tv & w_tl) begin
        r_acc1_out <= w_acc1_nxt;
        r_acc2_out <= w_acc2_nxt;
        r_cnt_out  <= w_cnt_nxt;
      end else begin
        r_acc1_out <= r_acc1_out;
        r_acc2_out <= r_acc2_out;
        r_cnt_out  <= r_cnt_out;
      end
    end
  end

  assign io.acc1      = r_acc1_out;
  assign io.acc2      = r_acc2_out;
  assign io.beat_cnt  = r_cnt_out;
  assign io.out_valid = r_out_valid;

endmodule

// File: tb/tb_mac_acc_36.sv
// ---------------------------------------------------------------------------
// tb_mac_acc_36
// Directed, table-driven bench for mac_acc_36 plus hand-written sequences
// for back-to-back bursts, reset mid-burst, in_last without in_valid and a
// long wrapping burst. Inputs are driven on the falling edge; a monitor on
// the falling edge logs every out_valid cycle with its cycle number.
// ---------------------------------------------------------------------------
module tb_mac_acc_36;
  import mac36_pkg::*;

  localparam int BW  = N*PROD_W;
  // Edges between the sampling edge of the last beat and the edge that
  // raises out_valid (seven register stages, the first is the sampling one).
  localparam int LAT = 6;

  typedef struct {
    string        name;
    logic [BW-1:0] p1;
    logic [BW-1:0] p2;
    int           beats;
    int           gap_after;
    int           gap_len;
    logic [31:0]  e_acc1;
    logic [31:0]  e_acc2;
    logic [15:0]  e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   drv_t = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] q_a1[$];
  logic [31:0] q_a2[$];
  logic [15:0] q_c[$];
  int          q_t[$];

  mac_acc_36_if bus ();

  mac_acc_36 u_dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      q_a1.push_back(bus.acc1);
      q_a2.push_back(bus.acc2);
      q_c.push_back(bus.beat_cnt);
      q_t.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_q();
    q_a1.delete();
    q_a2.delete();
    q_c.delete();
    q_t.delete();
  endtask

  // One beat, sampled at the next rising edge; drv_t is that edge's cycle.
  task automatic beat(input logic [BW-1:0] p1, input logic [BW-1:0] p2,
                      input logic v, input logic l);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_last  = l;
    bus.prod1    = p1;
    bus.prod2    = p2;
    drv_t        = cyc + 1;
  endtask

  task automatic idle(input int n);
    logic [BW-1:0] z;
    z = {BW{1'b0}};
    for (int i = 0; i < n; i++) beat(z, z, 1'b0, 1'b0);
  endtask

  function automatic logic [BW-1:0] fill(input logic [15:0] v);
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [BW-1:0] ramp();
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*16 +: 16] = 16'(i + 1);
    return r;
  endfunction

  function automatic logic [BW-1:0] top_lane(input logic [15:0] v);
    logic [BW-1:0] r;
    r = {BW{1'b0}};
    r[BW-1 -: 16] = v;
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input logic [BW-1:0] p1,
                              input logic [BW-1:0] p2, input int beats,
                              input int ga, input int gl, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [15:0] c);
    vec_t v;
    v.name = nm; v.p1 = p1; v.p2 = p2; v.beats = beats;
    v.gap_after = ga; v.gap_len = gl;
    v.e_acc1 = a1; v.e_acc2 = a2; v.e_cnt = c;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int t_last;
    t_last = 0;
    clear_q();
    for (int b = 1; b <= v.beats; b++) begin
      beat(v.p1, v.p2, 1'b1, (b == v.beats));
      if (b == v.beats) t_last = drv_t;
      if (b == v.gap_after) idle(v.gap_len);
    end
    idle(12);
    chk({v.name, "/pulses"}, q_a1.size(), 1);
    if (q_a1.size() > 0) begin
      chk({v.name, "/acc1"}, q_a1[0], v.e_acc1);
      chk({v.name, "/acc2"}, q_a2[0], v.e_acc2);
      chk({v.name, "/cnt"}, q_c[0], v.e_cnt);
      chk({v.name, "/latency"}, q_t[0] - t_last, LAT);
    end
    chk({v.name, "/hold_acc1"}, bus.acc1, v.e_acc1);
    chk({v.name, "/hold_cnt"}, bus.beat_cnt, v.e_cnt);
  endtask

  initial begin
    vec_t        vt[6];
    logic [BW-1:0] zero;
    int          t0;

    zero = {BW{1'b0}};
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.prod1    = zero;
    bus.prod2    = zero;

    vt[0] = mk("unit",     fill(16'h0001), fill(16'h0002), 1, 0, 0,
               32'd36, 32'd72, 16'd1);
    vt[1] = mk("neg_gap",  fill(16'hFFFF), zero, 4, 2, 2,
               32'hFFFFFF70, 32'h0, 16'd4);
    vt[2] = mk("ramp",     zero, ramp(), 1, 0, 0,
               32'h0, 32'd666, 16'd1);
    vt[3] = mk("min_lane", zero, top_lane(16'h8000), 1, 0, 0,
               32'h0, 32'hFFFF8000, 16'd1);
    vt[4] = mk("extremes", fill(16'h7FFF), fill(16'h8000), 3, 0, 0,
               32'h0035FF94, 32'hFFCA0000, 16'd3);
    vt[5] = mk("mixed",    fill(16'h0100), fill(16'hFFFE), 2, 0, 0,
               32'h00004800, 32'hFFFFFF70, 16'd2);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst/acc1", bus.acc1, 32'h0);
    chk("rst/acc2", bus.acc2, 32'h0);
    chk("rst/cnt", bus.beat_cnt, 16'h0);
    chk("rst/out_valid", bus.out_valid, 1'b0);
    rst = 1'b0;
    idle(2);

    for (int k = 0; k < 6; k++) run_vec(vt[k]);

    // Three back-to-back single-beat bursts
    clear_q();
    beat(fill(16'h0001), zero, 1'b1, 1'b1);
    t0 = drv_t;
    beat(fill(16'h0002), zero, 1'b1, 1'b1);
    beat(fill(16'h0003), zero, 1'b1, 1'b1);
    idle(12);
    chk("b2b/pulses", q_a1.size(), 3);
    if (q_a1.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("b2b/acc1_%0d", k), q_a1[k], 32'(36 * (k + 1)));
        chk($sformatf("b2b/cnt_%0d", k), q_c[k], 16'd1);
        chk($sformatf("b2b/time_%0d", k), q_t[k] - t0, LAT + k);
      end
    end

    // Reset mid-burst: two beats already accumulated, one in flight,
    // two more presented while reset is high; then a fresh 2-beat burst.
    clear_q();
    beat(fill(16'h0001), zero, 1'b1, 1'b0);
    beat(fill(16'h0001), zero, 1'b1, 1'b0);
    idle(8);
    beat(fill(16'h0001), zero, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst/acc1", bus.acc1, 32'h0);
    chk("midrst/cnt", bus.beat_cnt, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    idle(3);
    beat(fill(16'h0001), zero, 1'b1, 1'b0);
    beat(fill(16'h0001), zero, 1'b1, 1'b1);
    t0 = drv_t;
    idle(12);
    chk("midrst/pulses", q_a1.size(), 1);
    if (q_a1.size() > 0) begin
      chk("midrst/acc1_out", q_a1[0], 32'd72);
      chk("midrst/cnt_out", q_c[0], 16'd2);
      chk("midrst/latency", q_t[0] - t0, LAT);
    end

    // in_last without in_valid does nothing
    clear_q();
    for (int k = 0; k < 4; k++) beat(fill(16'h0005), fill(16'h0005), 1'b0, 1'b1);
    idle(12);
    chk("last_novalid/pulses", q_a1.size(), 0);
    chk("last_novalid/hold", bus.acc1, 32'd72);

    // Long burst wrapping past 2^31: 1821 * 36 * 32767 mod 2^32
    clear_q();
    for (int b = 1; b <= 1821; b++) beat(fill(16'h7FFF), zero, 1'b1, (b == 1821));
    idle(12);
    chk("long/pulses", q_a1.size(), 1);
    if (q_a1.size() > 0) begin
      chk("long/acc1", q_a1[0], 32'h8008FFEC);
      chk("long/acc2", q_a2[0], 32'h0);
      chk("long/cnt", q_c[0], 16'd1821);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_acc_36.md
Name: mac_acc_36

Overview:
- Downstream stage of the 36-lane dual-product multiplier array. It consumes both 36×16-bit product buses (out1 lanes, out2 lanes) every cycle.
- Each bus is reduced with a pipelined adder tree into one 22-bit sum per cycle. Sums are accumulated over a burst of valid beats delimited by in_last.
- Emits two ACC_W-bit dot-product results with a one-cycle out_valid pulse.
- There is no backpressure anywhere: the multiplier array is free-running and so is this block.

Parameters:
- N, 36, number of product lanes per bus.
- PROD_W, 16, width of each signed product.
- ACC_W, 32, accumulator and result width. Must be ≥ SUM_W.
- CNT_W, 16, beat-counter width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  products on prod1/prod2 are a valid beat. Must already be aligned to the multiplier output latency.
- in_last  input  1  qualifies the final beat of a burst. Ignored when in_valid=0.
- prod1  input  PROD_W*N  lane i occupies bits [16*i-1 -: 16], i=1..N; signed two's complement.
- prod2  input  PROD_W*N  same layout, second product bus.
- acc1  output  ACC_W  burst sum of prod1. Valid only when out_valid=1.
- acc2  output  ACC_W  burst sum of prod2.
- beat_cnt  output  CNT_W  number of valid beats in the reported burst.
- out_valid  output  1  single-cycle pulse per completed burst.

Behaviour:
- Reset values, all at the clock edge with rst=1:
  - acc1, acc2, beat_cnt = 0; out_valid = 0.
  - Accumulators, beat counter and all tree valid/last pipeline bits are cleared.
  - Tree data registers need not be cleared.
- Adder tree:
  - 6 registered levels: 36→18→9→5→3→2→1.
  - Pairs are sign-extended by 1 bit per level. An odd leftover element is registered through the level with sign extension.
  - The final sum is SUM_W = 22 bits and cannot overflow (36 × 2^15 < 2^21).
- Sideband: in_valid and in_last propagate through a 6-stage shift register in lockstep with the tree data.
- Accumulate stage, one register, driven by the tree-output valid (tv), last (tl) and sum:
  - tv=0: accumulators and beat counter hold.
  - tv=1 and first beat of a burst (the first_flag register, set at reset and after every tl): accumulator loads sign-extended sum; count loads 1.
  - tv=1 and not first beat: accumulator += sign-extended sum, wrapping modulo 2^ACC_W with no saturation; count += 1, saturating at all-ones.
  - tv=1 and tl=1: the updated values are captured into acc1/acc2/beat_cnt and out_valid=1 on the same edge, and first_flag is set.
- Latency: a beat with in_valid=in_last=1 at edge t produces out_valid=1 at edge t+7.
- Bursts:
  - Back-to-back bursts, including consecutive single-beat bursts, are supported at full rate with no mixing between bursts.
  - Gaps (in_valid=0) inside a burst are allowed.
- Output hold: acc1/acc2/beat_cnt hold their last reported values while out_valid=0.
- Reset mid-burst: the partial burst is discarded and beats in flight in the tree are dropped. The next valid beat after rst deasserts starts a new burst.
- in_valid=0 with in_last=1: no effect.

Decomposition:
- Package mac36_pkg holds N, PROD_W, SUM_W=22, TREE_LAT=6, and the lane-slice helper convention.
- Sub-module adder_tree_36: pipelined signed reduction of N×PROD_W to SUM_W with a 1-bit valid/last sideband. Instantiated twice, once per product bus; only one instance needs to carry the sideband.
- The accumulate/control logic stays in mac_acc_36.

Test Plan:
- All lanes of prod1 = 16'h0001, prod2 = 16'h0002, one beat with last → at t+7: acc1=36, acc2=72, beat_cnt=1, out_valid high for exactly 1 cycle.
- All prod1 lanes = 16'hFFFF, 4 beats with last on beat 4 and a 2-cycle in_valid gap after beat 2 → acc1 = 32'hFFFFFF70 (−144), beat_cnt=4.
- Lane i of prod2 = i (1..36), single beat → acc2=666. Lane 36 = 16'h8000, others 0 → acc2 = 32'hFFFF8000.
- Three consecutive single-beat bursts with all lanes = 1, 2, 3 → out_valid on three consecutive cycles with acc1 = 36, 72, 108.
- 5 beats of lanes=1, rst pulsed after beat 3, then a fresh 2-beat burst → only one out_valid, acc1=72, beat_cnt=2.
- All prod1 lanes = 16'h7FFF, 1821-beat burst → acc1 = (1821 × 1179612) mod 2^32, interpreted signed (wrapped negative), beat_cnt=1821.
